// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_unit
//  Description : Fetch-stage next-PC selector and PC register; redirects
//                that arrive during a stall are held and applied on release.
//  Revision    : 1.0
// ============================================================================
module pc_next_unit #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter int              STEP      = 4,
   parameter bit              VECTORED  = 1'b1,
   parameter int              CAUSE_W   = 5
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_stall,
   input  logic               i_trap,
   input  logic               i_trap_irq,
   input  logic [CAUSE_W-1:0] i_trap_cause,
   input  logic [XLEN-1:0]    i_mtvec,
   input  logic               i_mret,
   input  logic [XLEN-1:0]    i_mepc,
   input  logic               i_restore,
   input  logic               i_restore_taken,
   input  logic [XLEN-1:0]    i_restore_target,
   input  logic [XLEN-1:0]    i_restore_pc,
   input  logic               i_pred_taken,
   input  logic [XLEN-1:0]    i_pred_target,
   output logic [XLEN-1:0]    o_pc,
   output logic [XLEN-1:0]    o_nxt_pc,
   output logic               o_redirect,
   output logic               o_pending
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   // Redirect classes, ordered so that a numeric compare gives priority.
   localparam logic [1:0] c_cls_none    = 2'd0;
   localparam logic [1:0] c_cls_restore = 2'd1;
   localparam logic [1:0] c_cls_mret    = 2'd2;
   localparam logic [1:0] c_cls_trap    = 2'd3;

   localparam logic [XLEN-1:0] c_step = XLEN'(STEP);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_pend_tgt;
   logic [XLEN-1:0]   w_pend_tgt_nxt;
   logic [1:0]        r_pend_cls;
   logic [1:0]        w_pend_cls_nxt;

   logic [XLEN-1:0]   w_vec_off;
   logic [XLEN-1:0]   w_trap_tgt;
   logic [XLEN-1:0]   w_rst_tgt;
   logic [XLEN-1:0]   w_seq_tgt;
   logic [XLEN-1:0]   w_live_tgt;
   logic [1:0]        w_live_cls;
   logic              w_live_wins;

   assign w_vec_off  = {{(XLEN-CAUSE_W){1'b0}}, i_trap_cause} << 2;
   assign w_trap_tgt = {i_mtvec[XLEN-1:2], 2'b00} +
                       ((VECTORED && (i_mtvec[1:0] == 2'b01) && i_trap_irq) ? w_vec_off : '0);
   assign w_rst_tgt  = i_restore_taken ? i_restore_target : (i_restore_pc + c_step);
   assign w_seq_tgt  = i_pred_taken ? i_pred_target : (r_pc + c_step);

   always_comb begin
      w_live_cls = c_cls_none;
      w_live_tgt = w_seq_tgt;
      if (i_trap) begin
         w_live_cls = c_cls_trap;
         w_live_tgt = w_trap_tgt;
      end else if (i_mret) begin
         w_live_cls = c_cls_mret;
         w_live_tgt = i_mepc;
      end else if (i_restore) begin
         w_live_cls = c_cls_restore;
         w_live_tgt = w_rst_tgt;
      end
   end

   // Pending class is NONE in RUN, so any live redirect wins there.
   assign w_live_wins = (w_live_cls != c_cls_none) && (w_live_cls >= r_pend_cls);

   always_comb begin
      o_nxt_pc       = w_live_tgt;
      o_redirect     = (w_live_cls != c_cls_none);
      w_state_nxt    = r_state;
      w_pend_tgt_nxt = r_pend_tgt;
      w_pend_cls_nxt = r_pend_cls;
      case (r_state)
         ST_RUN: begin
            if (i_stall && (w_live_cls != c_cls_none)) begin
               w_pend_tgt_nxt = w_live_tgt;
               w_pend_cls_nxt = w_live_cls;
               w_state_nxt    = ST_PEND;
            end
         end
         ST_PEND: begin
            if (!w_live_wins) begin
               o_nxt_pc   = r_pend_tgt;
               o_redirect = 1'b1;
            end
            if (i_stall) begin
               if (w_live_wins) begin
                  w_pend_tgt_nxt = w_live_tgt;
                  w_pend_cls_nxt = w_live_cls;
               end
            end else begin
               w_pend_tgt_nxt = '0;
               w_pend_cls_nxt = c_cls_none;
               w_state_nxt    = ST_RUN;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_RUN;
         r_pc       <= RESET_VEC;
         r_pend_tgt <= '0;
         r_pend_cls <= c_cls_none;
      end else begin
         r_state    <= w_state_nxt;
         r_pend_tgt <= w_pend_tgt_nxt;
         r_pend_cls <= w_pend_cls_nxt;
         if (!i_stall) begin
            r_pc <= o_nxt_pc;
         end
      end
   end

   assign o_pc      = r_pc;
   assign o_pending = (r_state == ST_PEND);

endmodule
`default_nettype wire
